// File: rtl/rs_encoder_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^8) (poly 0x11D): forwards K message
// symbols, then appends NSYM parity symbols (remainder of m(x)*x^NSYM mod g(x)), highest degree first.
module rs_encoder_stream #(
  parameter int m = 255,
  parameter int SIZE = $clog2(m),
  parameter int K = 251,
  parameter int NSYM = 4,
  parameter logic [(NSYM+1)*SIZE-1:0] GEN = 40'h010F367840
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last
);
  localparam int CW = $clog2(m + 1);
  localparam logic [SIZE-1:0] POLY = SIZE'(9'h11D);

  typedef enum logic {DATA, PARITY} state_t;

  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[SIZE-2:0], 1'b0} ^ (sh[SIZE-1] ? POLY : '0);
    end
    return acc;
  endfunction

  state_t          state_reg, state_next;
  logic [CW-1:0]   sym_cnt_reg, sym_cnt_next;
  logic [SIZE-1:0] r_reg [NSYM];
  logic [SIZE-1:0] r_next [NSYM];
  logic [SIZE-1:0] prod [NSYM];
  logic [SIZE-1:0] out_data_reg, out_data_next;
  logic            out_valid_reg, out_valid_next;
  logic            out_last_reg, out_last_next;
  logic            out_free, accept;
  logic [SIZE-1:0] fb;

  assign out_free  = !out_valid_reg || out_ready;
  assign in_ready  = rst_n && (state_reg == DATA) && out_free;
  assign accept    = in_valid && in_ready;
  assign fb        = in_data ^ r_reg[NSYM-1];
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

  // Constant-coefficient multipliers; the monic top coefficient of g(x) is implicit.
  generate
    for (genvar gi = 0; gi < NSYM; gi++) begin : g_prod
      assign prod[gi] = gf_mul(GEN[gi*SIZE +: SIZE], fb);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    sym_cnt_next   = sym_cnt_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    for (int i = 0; i < NSYM; i++) r_next[i] = r_reg[i];

    case (state_reg)
      DATA: begin
        if (accept) begin
          r_next[0] = prod[0];
          for (int i = 1; i < NSYM; i++) r_next[i] = r_reg[i-1] ^ prod[i];
          out_data_next  = in_data;
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
          if (sym_cnt_reg == CW'(K - 1)) begin
            state_next   = PARITY;
            sym_cnt_next = '0;
          end else begin
            sym_cnt_next = sym_cnt_reg + 1'b1;
          end
        end else if (out_free) begin
          out_valid_next = 1'b0;
        end
      end
      PARITY: begin
        if (out_free) begin
          // Shifting zeros in leaves r cleared once the last parity is loaded.
          out_data_next  = r_reg[NSYM-1];
          out_valid_next = 1'b1;
          r_next[0] = '0;
          for (int i = 1; i < NSYM; i++) r_next[i] = r_reg[i-1];
          out_last_next = (sym_cnt_reg == CW'(NSYM - 1));
          if (sym_cnt_reg == CW'(NSYM - 1)) begin
            state_next   = DATA;
            sym_cnt_next = '0;
          end else begin
            sym_cnt_next = sym_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= DATA;
      sym_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      for (int i = 0; i < NSYM; i++) r_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      sym_cnt_reg   <= sym_cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      for (int i = 0; i < NSYM; i++) r_reg[i] <= r_next[i];
    end
  end
endmodule

// File: tb/tb_rs_encoder_stream.sv
// Scoreboard bench for rs_encoder_stream with K=4, NSYM=4: directed codewords, stalls,
// mid-codeword reset, back-to-back framing, and syndrome evaluation of every codeword.
module tb_rs_encoder_stream;
  localparam int K = 4;
  localparam int NSYM = 4;

  logic       clk, rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last;

  rs_encoder_stream #(.K(K), .NSYM(NSYM)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    bit         care;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          beat_cnt = 0;
  bit          contig = 1;
  int          first_acc, last_acc;
  logic [31:0] last_par = '0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Carry-less product followed by explicit reduction by 0x11D.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  // Monitor: pops the scoreboard on each transfer, checks stall stability and syndromes.
  initial begin
    logic [7:0] cw [16];
    int         cw_n;
    int         start_cyc;
    bit         stalled;
    logic [7:0] held_d;
    logic       held_l;
    exp_t       e;
    logic [7:0] s, apow;
    cw_n = 0;
    start_cyc = 0;
    stalled = 0;
    held_d = '0;
    held_l = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cw_n = 0;
        stalled = 0;
      end else begin
        if (out_valid && !out_ready) begin
          if (stalled) begin
            chk(out_data == held_d && out_last == held_l, "stall_hold", {out_last, out_data}, {held_l, held_d});
            chk(in_ready == 1'b0, "stall_in_ready", 32'(in_ready), 0);
          end
          stalled = 1;
          held_d = out_data;
          held_l = out_last;
        end else begin
          stalled = 0;
        end
        if (out_valid && out_ready) begin
          beat_cnt++;
          if (sb.size() == 0) begin
            chk(0, "unexpected_beat", {out_last, out_data}, 0);
          end else begin
            e = sb.pop_front();
            if (e.care) chk(out_data == e.data, "out_data", 32'(out_data), 32'(e.data));
            chk(out_last == e.last, "out_last", 32'(out_last), 32'(e.last));
            $display("beat data=%02h last=%0d exp=%02h care=%0d", out_data, out_last, e.data, e.care);
          end
          if (cw_n == 0) start_cyc = cyc;
          if (cw_n < 16) cw[cw_n] = out_data;
          cw_n++;
          if (out_last) begin
            apow = 8'h01;
            for (int j = 0; j < NSYM; j++) begin
              s = '0;
              for (int k = 0; k < cw_n && k < 16; k++) s = tb_mul(s, apow) ^ cw[k];
              chk(s == 8'h00, "syndrome", 32'(s), 0);
              apow = tb_mul(apow, 8'h02);
            end
            chk(cw_n == K + NSYM, "cw_length", 32'(cw_n), K + NSYM);
            if (contig) chk(cyc - start_cyc == K + NSYM - 1, "contig_beats", 32'(cyc - start_cyc), K + NSYM - 1);
            if (cw_n >= NSYM && cw_n <= 16) last_par = {cw[cw_n-4], cw[cw_n-3], cw[cw_n-2], cw[cw_n-1]};
            cw_n = 0;
          end
        end
      end
    end
  end

  task automatic push_cw(input logic [31:0] msg, input logic [31:0] par, input bit care_par);
    exp_t e;
    for (int i = 0; i < K; i++) begin
      e.data = msg[31-8*i -: 8]; e.last = 0; e.care = 1;
      sb.push_back(e);
    end
    for (int i = 0; i < NSYM; i++) begin
      e.data = par[31-8*i -: 8]; e.last = (i == NSYM - 1); e.care = care_par;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bit acc;
    int n;
    in_valid = 1;
    in_data = d;
    acc = 0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) last_acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk(0, "accept_timeout", 32'(n), 0);
  endtask

  task automatic encode(input logic [31:0] msg);
    for (int i = 0; i < K; i++) begin
      send(msg[31-8*i -: 8]);
      if (i == 0) first_acc = last_acc;
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(sb.size() == 0, "drain", 32'(sb.size()), 0);
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk(out_valid == 0, "rst_out_valid", 32'(out_valid), 0);
    chk(out_data == 8'h00, "rst_out_data", 32'(out_data), 0);
    chk(out_last == 0, "rst_out_last", 32'(out_last), 0);
    chk(in_ready == 0, "rst_in_ready", 32'(in_ready), 0);
  endtask

  initial begin
    logic [31:0] msg, par;
    int          base, c1, c2, f2, f3;
    rst_n = 0; in_valid = 1; in_data = 8'h55; out_ready = 1;
    repeat (3) @(posedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    @(posedge clk); #1;

    // Unit impulse, doubled impulse (linearity), all-zero message.
    push_cw(32'h00000001, 32'h0F367840, 1); encode(32'h00000001); drain();
    push_cw(32'h00000002, 32'h1E6CF080, 1); encode(32'h00000002); drain();
    push_cw(32'h00000000, 32'h00000000, 1); encode(32'h00000000); drain();

    // Random messages: data forwarded exactly, parity judged by syndromes.
    for (int i = 0; i < 3; i++) begin
      msg = $urandom;
      push_cw(msg, 32'h0, 0); encode(msg); drain();
    end

    // Stalled encode must reproduce the unstalled parity.
    msg = 32'h5AA53CC3;
    push_cw(msg, 32'h0, 0); encode(msg); drain();
    par = last_par;
    contig = 0;
    push_cw(msg, par, 1);
    base = beat_cnt;
    fork
      encode(msg);
      begin
        wait (beat_cnt == base + 1);
        @(posedge clk); #1; out_ready = 0;
        repeat (3) @(posedge clk); #1; out_ready = 1;
        wait (beat_cnt == base + 5);
        @(posedge clk); #1; out_ready = 0;
        repeat (3) @(posedge clk); #1; out_ready = 1;
      end
    join
    drain();
    contig = 1;

    // Reset after two symbols: partial codeword discarded.
    push_cw(32'h12340000, 32'h0, 0);
    send(8'h12); send(8'h34);
    rst_n = 0; in_valid = 1;
    repeat (2) @(posedge clk);
    reset_checks();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    @(posedge clk); #1;
    push_cw(32'h00000001, 32'h0F367840, 1); encode(32'h00000001); drain();

    // Back-to-back codewords with in_valid held high.
    push_cw(32'h00000001, 32'h0F367840, 1);
    push_cw(32'h00000002, 32'h1E6CF080, 1);
    push_cw(32'h00000000, 32'h00000000, 1);
    encode(32'h00000001); c1 = last_acc;
    encode(32'h00000002); f2 = first_acc; c2 = last_acc;
    encode(32'h00000000); f3 = first_acc;
    chk(f2 - c1 - 1 == NSYM, "b2b_gap1", 32'(f2 - c1 - 1), NSYM);
    chk(f3 - c2 - 1 == NSYM, "b2b_gap2", 32'(f3 - c2 - 1), NSYM);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_encoder_stream.md
Name: rs_encoder_stream

Overview:
- Streaming systematic Reed-Solomon encoder over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Accepts K message symbols one per handshake and forwards them unchanged.
- After the K-th message symbol it appends NSYM parity symbols, the remainder of m(x)*x^NSYM mod g(x).
- Transmit-side counterpart of the team's GF polynomial evaluation / syndrome path: its codewords are exactly those whose evaluation at alpha^0..alpha^(NSYM-1) is zero.

Parameters:
- m, 255, field order minus one; codeword length limit K+NSYM <= m.
- SIZE, $clog2(m) (=8), symbol width in bits.
- K, 251, message symbols per codeword.
- NSYM, 4, parity symbols per codeword.
- GEN, 40'h010F367840, generator g(x) coefficients packed as (NSYM+1)*SIZE bits, highest degree in the top symbol. The top symbol must be 0x01. The default is g(x) = prod_{i=0..3}(x - alpha^i) = x^4+0x0F x^3+0x36 x^2+0x78 x+0x40.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  SIZE  message symbol, highest-degree coefficient first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  encoder accepts in_data this cycle.
- out_data  output  SIZE  codeword symbol.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the final parity symbol of a codeword.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=DATA, sym_cnt=0, all parity registers r[0..NSYM-1]=0.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready is 0 while rst_n=0.
  - Reset mid-codeword discards the partial codeword; no parity is emitted for it.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Output stage: a single output register. out_free = !out_valid | out_ready.
- State DATA:
  - in_ready = out_free.
  - On accept of d, in one cycle:
    - fb = d ^ r[NSYM-1]
    - r[0] <= g0*fb
    - r[i] <= r[i-1] ^ gi*fb for i = 1..NSYM-1
    - out_data <= d, out_valid <= 1, out_last <= 0, sym_cnt++.
  - All products are GF(2^8) multiplies mod 0x11D. Additions are XOR.
  - If out_free and no accept, out_valid <= 0.
  - When the accepted symbol is the K-th (sym_cnt==K-1): next state PARITY, sym_cnt <= 0.
- State PARITY:
  - in_ready=0.
  - Each cycle with out_free, in order:
    - out_data <= r[NSYM-1], out_valid <= 1
    - shift r[i] <= r[i-1], r[0] <= 0
    - out_last <= (sym_cnt==NSYM-1), sym_cnt++.
  - After loading the NSYM-th parity: state DATA, sym_cnt <= 0, and r is all zero again.
- Latency and throughput:
  - Latency in_data to out_data is 1 cycle.
  - Full throughput with out_ready held 1: K+NSYM consecutive output beats per codeword.
  - in_ready is low for exactly NSYM cycles between codewords.
  - The first symbol of the next codeword may be accepted in the same cycle the last parity transfers out.
- Simultaneous in_valid without in_ready: ignored, and the input is not consumed.
- Parity order on the wire: highest degree first, r[NSYM-1] .. r[0].

Test Plan:
- K=4, NSYM=4, GEN default, all handshakes always ready.
  - Message 00 00 00 01 -> out 00 00 00 01 0F 36 78 40, out_last only on 0x40, 8 consecutive valid beats.
- Same configuration, message 00 00 00 02 -> parity 1E 6C F0 80 (linearity check).
- Message 00 00 00 00 -> parity 00 00 00 00.
- Encode random messages, then evaluate each codeword at alpha^0..alpha^3 using the existing GF polynomial evaluator -> all syndromes zero.
- Hold out_ready=0 for 3 cycles during both DATA and PARITY beats -> out_data/out_last stable and in_ready=0 while stalled. Result matches the unstalled output.
- Assert rst_n=0 after 2 message symbols, release, then send message 00 00 00 01 -> no stale parity; output 00 00 00 01 0F 36 78 40 exactly.
- Back-to-back codewords with in_valid held high -> in_ready low for exactly 4 cycles per codeword. The second codeword's parity is independent of the first.
